// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: decoder FSM encodings and output polarity selectors.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } sc_state_e;

  localparam int SC_UNIPOLAR = 0;
  localparam int SC_BIPOLAR  = 1;

endpackage

// File: rtl/sc_ones_counter.sv
// Sample/ones counter pair for one decode window of 2^WIDTH qualified samples.
// window_done flags the cycle whose enabled sample is the last one of the window.
module sc_ones_counter #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic           bit_in,
  output logic [WIDTH:0] ones,
  output logic           window_done
);

  localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] samples_q, samples_d;
  logic [WIDTH:0] ones_q, ones_d;

  always_comb begin
    samples_d = samples_q;
    ones_d    = ones_q;
    if (clr) begin
      samples_d = '0;
      ones_d    = '0;
    end else if (en) begin
      samples_d = samples_q + ONE;
      if (bit_in) begin
        ones_d = ones_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples_q <= '0;
      ones_q    <= '0;
    end else begin
      samples_q <= samples_d;
      ones_q    <= ones_d;
    end
  end

  assign ones        = ones_q;
  assign window_done = en && !clr && (samples_q == LAST);

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary readout: counts ones over 2^WIDTH valid samples, then holds a
// unipolar (saturated) or bipolar (offset, clamped) result behind a valid/ready handshake.
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BIPOLAR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready
);

  sc_state_e        state_q, state_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   ones, final_ones;
  logic             cnt_clr, cnt_en, window_done;

  assign cnt_en = (state_q == ST_COUNT) && bit_valid && !abort;

  sc_ones_counter #(.WIDTH(WIDTH)) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (cnt_clr),
    .en          (cnt_en),
    .bit_in      (bit_in),
    .ones        (ones),
    .window_done (window_done)
  );

  // Include the sample landing this cycle so the result registers with the last sample.
  assign final_ones = ones + {{WIDTH{1'b0}}, bit_in};

  // A full count (2^WIDTH) is the only value with the top bit set; bipolar offset is an MSB flip.
  always_comb begin
    result = final_ones[WIDTH-1:0];
    if (BIPOLAR == SC_BIPOLAR) begin
      if (final_ones[WIDTH]) begin
        result            = '1;
        result[WIDTH-1]   = 1'b0;
      end else begin
        result[WIDTH-1] = ~final_ones[WIDTH-1];
      end
    end else if (final_ones[WIDTH]) begin
      result = '1;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    cnt_clr     = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      cnt_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_COUNT;
            cnt_clr = 1'b1;
          end
        end
        ST_COUNT: begin
          if (window_done) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_value_d = result;
          end
        end
        ST_HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            cnt_clr     = 1'b1;
            state_d     = continuous ? ST_COUNT : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;

endmodule

// File: doc/sc_bitstream_decoder.md
# sc_bitstream_decoder

Converts a stochastic bitstream, such as the `sum` output of `sc_n_adder_chain`, back into a binary number by counting ones over a fixed window of 2^WIDTH valid samples. This is the stochastic-to-binary readout at the end of an SC datapath, the inverse of the stochastic number generators that feed it. It supports unipolar or bipolar output, single-shot or continuous windows, and a valid/ready output handshake.

## Interface
- `WIDTH`, default 8: log2 of the window length; output width in bits.
- `BIPOLAR`, default 0: 0 gives an unsigned count; 1 gives a signed two's-complement bipolar value.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a window when the block is in IDLE.
- `continuous` in 1: when 1, the next window re-arms automatically after each output handoff.
- `abort` in 1: discards the window in progress and returns to IDLE.
- `bit_in` in 1: stochastic stream bit.
- `bit_valid` in 1: qualifies `bit_in`; only qualified cycles count as samples.
- `busy` out 1: high in COUNT and HOLD.
- `out_value` out WIDTH: decoded value, held stable while `out_valid`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.

## Operation
- States: IDLE, COUNT, HOLD.
- IDLE:
  - `start`=1 → COUNT.
  - Sample and ones counters clear on entry to COUNT.
- COUNT:
  - Each cycle with `bit_valid`=1 increments the sample counter.
  - When `bit_in`=1 on such a cycle, the ones counter also increments.
  - Both counters are WIDTH+1 bits wide.
  - After the 2^WIDTH-th valid sample → HOLD.
- HOLD:
  - `out_value` and `out_valid` are registered.
  - On `out_valid && out_ready`: go to COUNT with counters cleared if `continuous`=1, else go to IDLE.
  - `bit_in` is ignored in HOLD.
- Unipolar (BIPOLAR=0):
  - c is the ones count, in the range 0..2^WIDTH.
  - `out_value` = min(c, 2^WIDTH−1), i.e. c=2^WIDTH saturates to all ones.
- Bipolar (BIPOLAR=1):
  - `out_value` = c − 2^(WIDTH−1), signed.
  - Clamped to [−2^(WIDTH−1), 2^(WIDTH−1)−1], so c=2^WIDTH gives +2^(WIDTH−1)−1.
- Boundary conditions:
  - `start` in COUNT or HOLD is ignored.
  - `abort` has priority over every other input. From COUNT or HOLD it goes to IDLE on the next edge and `out_valid` drops. A pending result is lost.
  - `start` and `abort` together in IDLE: stay in IDLE.
  - Gaps in `bit_valid` stretch the window and do not end it early.
  - Clearing `continuous` while in COUNT: the current window completes, then the block returns to IDLE after handoff.
  - `rst_n` low at any time: all state clears immediately.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_value`=0, state IDLE, counters 0.
- `start` sampled at edge t: `busy`=1 from t+1, and the first countable sample is at edge t+1.
- Final valid sample at edge k: `out_valid`=1 and `out_value` valid after edge k. Latency is one cycle from the last sample.
- A continuous window with `bit_valid` held high completes every 2^WIDTH+1 cycles, counting the handoff cycle, when `out_ready` is held high.
- `out_valid` never deasserts without a handshake, `abort`, or reset.
- `out_value` is constant while `out_valid`=1.

## Structure
- Shared `sc_pkg` holds:
  - State encodings: IDLE=2'd0, COUNT=2'd1, HOLD=2'd2.
  - Polarity constants: SC_UNIPOLAR=0, SC_BIPOLAR=1.
- Sub-module `sc_ones_counter`:
  - Parameterized WIDTH+1-bit counter pair (samples, ones).
  - Synchronous clear and enable, plus a `window_done` flag.
- The top level holds:
  - The FSM.
  - The saturation and bipolar offset logic, which is combinational into the output register.

## Test plan
1. WIDTH=4, unipolar, `start` pulse, 16 cycles of `bit_in`=1 with `bit_valid`=1 → `out_value`=15 (saturated), `out_valid` 1 cycle after the 16th sample.
2. WIDTH=4, alternating 1010…, with `bit_valid` low every third cycle → window takes 16 valid samples. Expected `out_value` = the ones counted among those samples, checked by a scoreboard.
3. WIDTH=4, BIPOLAR=1:
   - all zeros → −8
   - 8 ones → 0
   - all ones → +7
4. Backpressure: `out_ready` held low for 5 cycles after `out_valid` → `out_valid` and `out_value` stable throughout. Transfer on the first ready cycle, then IDLE with `busy`=0.
5. `continuous`=1, `out_ready`=1, ones density 0.25 from an LFSR stream → three consecutive results each within ±2 of 4, with no idle cycles between windows.
6. `abort` midway through COUNT, and `rst_n` pulsed low mid-window on a separate run → `busy`=0 and `out_valid`=0. A new `start` then yields a full, correct window.
